// File: rtl/mux_rr_sampler_if.sv
// Handshake and mux-control bundle for mux_rr_sampler.
// master = sampler side, slave = mux/consumer side.
interface mux_rr_sampler_if #(
    parameter int N = 9,
    parameter int M = 4
);
    logic [N-1:0] req;
    logic [M-1:0] sel;
    logic         mux_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic [M-1:0] out_idx;

    modport master (
        input  req,
        output sel,
        input  mux_out,
        output out_valid,
        input  out_ready,
        output out_bit,
        output out_idx
    );

    modport slave (
        output req,
        input  sel,
        output mux_out,
        input  out_valid,
        output out_ready,
        input  out_bit,
        input  out_idx
    );
endinterface

// File: rtl/mux_rr_sampler.sv
// Round-robin sampler: grants a request, drives the mux select,
// waits one settle cycle, then presents the captured bit.
module mux_rr_sampler #(
    parameter int N = 9,
    parameter int M = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_sampler_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int W = M + 1;
    localparam logic [M-1:0] LAST = M'(N - 1);

    state_e       state_q, state_d;
    logic [M-1:0] sel_q, sel_d;
    logic [M-1:0] ptr_q, ptr_d;
    logic [M-1:0] idx_q, idx_d;
    logic         bit_q, bit_d;

    logic         any_req;
    logic         arb_en;
    logic         cap_en;
    logic [M-1:0] gnt;
    logic [W-1:0] cand;
    logic         found;

    assign any_req = |bus.req;

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        gnt   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + W'(k);
            if (cand >= W'(N)) begin
                cand = cand - W'(N);
            end
            if (!found && bus.req[cand[M-1:0]]) begin
                gnt   = cand[M-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = SETTLE;
            end
            SETTLE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = any_req ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (arb_en) begin
            sel_d = gnt;
            ptr_d = (gnt == LAST) ? '0 : gnt + 1'b1;
        end
        if (cap_en) begin
            bit_d = bus.mux_out;
            idx_d = sel_q;
        end
    end

    always_comb begin
        arb_en = any_req &&
                 ((state_q == IDLE) ||
                  ((state_q == HOLD) && bus.out_ready));
        cap_en        = (state_q == SETTLE);
        bus.out_valid = (state_q == HOLD);
        bus.sel       = sel_q;
        bus.out_bit   = bit_q;
        bus.out_idx   = idx_q;
    end

endmodule

// File: tb/tb_mux_rr_sampler.sv
// Directed and random stimulus for mux_rr_sampler against
// a transaction-level round-robin model.
module tb_mux_rr_sampler;

    localparam int N = 9;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] mux_data = '0;

    int errors = 0;
    int checks = 0;

    mux_rr_sampler_if #(.N(N), .M(M)) bus ();

    mux_rr_sampler #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mux_out = (int'(bus.sel) < N) ? mux_data[bus.sel] : 1'b0;

    // Model: phase 0 = waiting, 1 = select settling, 2 = presenting.
    int   m_phase = 0;
    int   m_ptr   = 0;
    int   m_sel   = 0;
    int   m_idx   = 0;
    logic m_bit   = 1'b0;
    logic m_valid = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_grant(input logic [N-1:0] r);
        for (int o = 0; o < N; o++) begin
            int c;
            c = (m_ptr + o) % N;
            if (r[c]) begin
                m_sel   = c;
                m_ptr   = (c + 1) % N;
                m_phase = 1;
                return;
            end
        end
        m_phase = 0;
    endtask

    task automatic m_edge();
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_sel = 0;
            m_idx = 0; m_bit = 1'b0; m_valid = 1'b0;
        end else if (m_phase == 0) begin
            if (bus.req != 0) m_grant(bus.req);
        end else if (m_phase == 1) begin
            m_bit = mux_data[m_sel];
            m_idx = m_sel;
            m_valid = 1'b1;
            m_phase = 2;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
            if (bus.req != 0) m_grant(bus.req);
            else m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("sel", int'(bus.sel), m_sel);
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("out_bit", int'(bus.out_bit), int'(m_bit));
        chk("out_idx", int'(bus.out_idx), m_idx);
    endtask

    initial begin
        int exp_idx;
        int nsamp;
        bus.req = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held with every request set.
        rst_n = 1'b0;
        bus.req = 9'h1FF;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_idx", int'(bus.out_idx), 0);

        // Single request, latency two edges, req dropped mid-flight.
        rst_n = 1'b1;
        bus.req = 9'b000010000;
        bus.out_ready = 1'b0;
        mux_data = 9'h1FF;
        tick();
        chk("lat_sel", int'(bus.sel), 4);
        chk("lat_valid0", int'(bus.out_valid), 0);
        bus.req = '0;
        tick();
        chk("lat_valid1", int'(bus.out_valid), 1);
        chk("lat_idx", int'(bus.out_idx), 4);
        chk("lat_bit", int'(bus.out_bit), 1);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_valid", int'(bus.out_valid), 0);

        // Back-to-back round robin from index 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req = 9'h1FF;
        bus.out_ready = 1'b1;
        mux_data = 9'h0A5;
        exp_idx = 0;
        nsamp = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (bus.out_valid) begin
                chk("rr_idx", int'(bus.out_idx), exp_idx);
                exp_idx = (exp_idx + 1) % N;
                nsamp++;
            end
        end
        chk("rr_count", nsamp, 11);

        // Stall in HOLD.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_idx", int'(bus.out_idx), 1);
            chk("stall_sel", int'(bus.sel), 1);
            chk("stall_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        chk("stall_next", int'(bus.out_idx), 2);

        // Grant 7, then wrap past 8 to 2 then 5.
        bus.req = 9'b010000000;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        chk("g7_idx", int'(bus.out_idx), 7);
        bus.req = 9'b000100100;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("wrap_a", int'(bus.out_idx), 2);
        tick();
        tick();
        chk("wrap_b", int'(bus.out_idx), 5);

        // Reset while presenting index 6.
        bus.req = 9'b001000000;
        tick();
        bus.out_ready = 1'b0;
        tick();
        chk("r6_idx", int'(bus.out_idx), 6);
        rst_n = 1'b0;
        tick();
        chk("r6_valid", int'(bus.out_valid), 0);
        chk("r6_sel", int'(bus.sel), 0);
        rst_n = 1'b1;
        bus.req = 9'h1FF;
        tick();
        chk("r6_gsel", int'(bus.sel), 0);
        tick();
        chk("r6_gidx", int'(bus.out_idx), 0);
        chk("r6_gvalid", int'(bus.out_valid), 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            bus.out_ready = 1'($urandom);
            mux_data = N'($urandom);
            rst_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_rr_sampler.md
MUX_RR_SAMPLER -- requirements
Module: mux_rr_sampler

Interface
REQ-001 The block SHALL have parameter N, default 9: the number of request lines, which is also the number of inputs on the downstream N-to-1 mux.
REQ-002 The block SHALL have parameter M, default 4: the width of the select and index signals; a legal configuration has N >= 1 and 2**M >= N.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port req, input, N bits: per-input sample requests, where bit i asks for mux input i.
REQ-006 The block SHALL have port sel, output, M bits: registered select that drives the mux select input.
REQ-007 The block SHALL have port mux_out, input, 1 bit: the combinational output of the mux fed by sel.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a captured sample is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the presented sample.
REQ-010 The block SHALL have port out_bit, output, 1 bit: the captured mux_out value.
REQ-011 The block SHALL have port out_idx, output, M bits: the input index that out_bit was captured from.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE and HOLD.
REQ-013 In IDLE with req != 0 at a clock edge, the block SHALL grant the lowest index i >= ptr with req[i]=1, wrapping from N-1 to 0; it SHALL register sel=i, set ptr=(i+1) mod N and go to SETTLE.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with sel, ptr and all outputs unchanged.
REQ-015 SETTLE SHALL last exactly one cycle; at its closing edge the block SHALL capture out_bit=mux_out and out_idx=sel, set out_valid=1 and go to HOLD.
REQ-016 In HOLD, out_valid, out_bit, out_idx and sel SHALL stay stable until an edge with out_ready=1.
REQ-017 At an edge in HOLD with out_ready=1 and req != 0, the block SHALL clear out_valid, arbitrate per REQ-013 and go directly to SETTLE (back-to-back mode: one sample per 2 cycles).
REQ-018 At an edge in HOLD with out_ready=1 and req == 0, the block SHALL clear out_valid and go to IDLE.
REQ-019 The block SHALL sample req only at arbitration edges; a req bit deasserted after its grant SHALL NOT cancel the capture in progress.
REQ-020 The block SHALL ignore out_ready whenever out_valid=0.
REQ-021 The block SHALL hold sel at its last granted value in IDLE and in HOLD; sel SHALL change only at arbitration edges.
REQ-022 ptr wrap: a grant of index N-1 SHALL set ptr=0; with N=1 ptr SHALL stay 0 and every grant SHALL be index 0.
REQ-023 All index arithmetic SHALL be M bits wide; sel and out_idx SHALL never take a value >= N.
REQ-024 Latency SHALL be fixed: a request sampled at edge t gives out_valid=1 after edge t+1.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL go to IDLE and set sel=0, ptr=0, out_valid=0, out_bit=0 and out_idx=0.
REQ-026 Reset SHALL take priority over every other event, including in SETTLE or HOLD; an in-flight sample SHALL be discarded and SHALL NOT be presented after reset.
REQ-027 The first arbitration after reset SHALL start searching at index 0.

Verification (N=9, M=4)
REQ-028 Hold rst_n=0 for 2 edges with req=9'h1FF -> sel=0, out_valid=0, out_bit=0, out_idx=0; no grant until rst_n=1.
REQ-029 After reset, apply req=9'b000010000 at edge t with mux_out=1 -> sel=4 after edge t; out_valid=1, out_idx=4, out_bit=1 after edge t+1.
REQ-030 Hold req=9'h1FF and out_ready=1 continuously -> out_idx sequence is 0,1,2,...,8,0,1, one new sample every 2 cycles.
REQ-031 Hold out_ready=0 for 5 cycles in HOLD with req=9'h1FF -> out_valid, out_bit, out_idx and sel unchanged, and no new grant; after out_ready=1, the next grant is out_idx+1.
REQ-032 After granting index 7 (ptr=8), apply req=9'b000100100 -> the next two grants are 2, then 5 (wrap past 8).
REQ-033 In HOLD with out_idx=6, assert rst_n=0 for 1 edge -> out_valid=0, sel=0; with req=9'h1FF, the next grant is index 0.
